// File: rtl/tick_bcd_timer.sv
// Tick-driven packed-BCD stopwatch core with start/stop/clear control.
// Ports: clkin, reset (sync, active-high), tick, start, stop, clear -> bcd, running, done, ovf.
// Define TICK_BCD_TIMER_WRAP_EN for wrapping overflow; default build saturates in OVF state.
module tick_bcd_timer #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  done,
  output logic                  ovf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_OVF
  } state_t;

  state_t              state;
  logic [PW-1:0]       psc;
  logic [4*DIGITS-1:0] bcd_inc;
  logic                carry;

  // Ripple +1 through all digits; carry left set means bcd was all-9s.
  always_comb begin
    carry   = 1'b1;
    bcd_inc = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state   <= S_IDLE;
      bcd     <= '0;
      psc     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state   <= S_IDLE;
        bcd     <= '0;
        psc     <= '0;
        running <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_HOLD: begin
            // stop outranks start, so stop+start keeps us parked
            if (!stop && start) begin
              state   <= S_RUN;
              running <= 1'b1;
            end
          end
          S_RUN: begin
            if (stop) begin
              state   <= S_HOLD;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (tick) begin
              if (psc == PS_LAST) begin
                psc <= '0;
`ifdef TICK_BCD_TIMER_WRAP_EN
                bcd <= bcd_inc;
                if (carry) ovf <= 1'b1;
`else
                if (carry) begin
                  ovf     <= 1'b1;
                  running <= 1'b0;
                  state   <= S_OVF;
                end else begin
                  bcd <= bcd_inc;
                end
`endif
              end else begin
                psc <= psc + PW'(1);
              end
            end
          end
          S_OVF: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Self-checking bench for tick_bcd_timer (PRESCALE=1 and PRESCALE=3 instances).
// Random and directed stimulus compared against a decimal-count reference model.
module tb_tick_bcd_timer;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  logic tick  = 1'b0;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic clear = 1'b0;

  logic [15:0] bcd0, bcd1;
  logic run0, run1, done0, done1, ovf0, ovf1;

  int errors = 0;
  int checks = 0;

  always #5 clkin = ~clkin;

  tick_bcd_timer #(.DIGITS(4), .PRESCALE(1)) dut0 (
    .clkin(clkin), .reset(reset), .tick(tick), .start(start),
    .stop(stop), .clear(clear), .bcd(bcd0), .running(run0),
    .done(done0), .ovf(ovf0)
  );

  tick_bcd_timer #(.DIGITS(4), .PRESCALE(3)) dut1 (
    .clkin(clkin), .reset(reset), .tick(tick), .start(start),
    .stop(stop), .clear(clear), .bcd(bcd1), .running(run1),
    .done(done1), .ovf(ovf1)
  );

  logic [15:0] obcd[2];
  logic        orun[2], odone[2], oovf[2];
  assign obcd[0]  = bcd0;
  assign obcd[1]  = bcd1;
  assign orun[0]  = run0;
  assign orun[1]  = run1;
  assign odone[0] = done0;
  assign odone[1] = done1;
  assign oovf[0]  = ovf0;
  assign oovf[1]  = ovf1;

  typedef enum int {M_IDLE, M_RUN, M_HOLD, M_OVF} mst_t;
  mst_t m_st[2];
  int   m_cnt[2];
  int   m_psc[2];
  bit   m_ovf[2];
  bit   m_done[2];
  int   pres[2] = '{1, 3};

  function automatic logic [15:0] to_bcd(int n);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic void model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset || clear) begin
        m_st[k]   = M_IDLE;
        m_cnt[k]  = 0;
        m_psc[k]  = 0;
        m_ovf[k]  = 0;
        m_done[k] = 0;
      end else begin
        m_done[k] = 0;
        case (m_st[k])
          M_IDLE, M_HOLD: if (!stop && start) m_st[k] = M_RUN;
          M_RUN: begin
            if (stop) begin
              m_st[k]   = M_HOLD;
              m_done[k] = 1;
            end else if (tick) begin
              m_psc[k]++;
              if (m_psc[k] == pres[k]) begin
                m_psc[k] = 0;
                if (m_cnt[k] == 9999) begin
                  m_ovf[k] = 1;
`ifdef TICK_BCD_TIMER_WRAP_EN
                  m_cnt[k] = 0;
`else
                  m_st[k] = M_OVF;
`endif
                end else begin
                  m_cnt[k]++;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  endfunction

  task automatic step();
    @(posedge clkin);
    model_update();
    #1;
  endtask

  task automatic tk(int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; tick = 1'b1;
    step(); step();
    reset = 1'b0; start = 1'b0; tick = 1'b0;
    step();
    checks++;
    if (bcd0 !== 16'h0000) begin
      errors++; $display("FAIL reset_bcd got %h expected 0000", bcd0);
    end
    checks++;
    if ({run0, done0, ovf0, run1, done1, ovf1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000000",
               {run0, done0, ovf0, run1, done1, ovf1});
    end
  endtask

  task automatic test_basic();
    tk(5);
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    checks++;
    if (bcd0 !== 16'h0015) begin
      errors++; $display("FAIL basic_bcd got %h expected 0015", bcd0);
    end
    checks++;
    if (run0 !== 1'b1) begin
      errors++; $display("FAIL basic_running got %b expected 1", run0);
    end
    checks++;
    if (bcd1 !== to_bcd(m_cnt[1])) begin
      errors++;
      $display("FAIL basic_ps3 got %h expected %h", bcd1, to_bcd(m_cnt[1]));
    end
  endtask

  task automatic test_ripple();
    tk(84);
    checks++;
    if (bcd0 !== 16'h0099) begin
      errors++; $display("FAIL ripple_pre99 got %h expected 0099", bcd0);
    end
    tk(1);
    checks++;
    if (bcd0 !== 16'h0100) begin
      errors++; $display("FAIL ripple_100 got %h expected 0100", bcd0);
    end
    tk(899);
    checks++;
    if (bcd0 !== 16'h0999) begin
      errors++; $display("FAIL ripple_pre999 got %h expected 0999", bcd0);
    end
    tk(1);
    checks++;
    if (bcd0 !== 16'h1000) begin
      errors++; $display("FAIL ripple_1000 got %h expected 1000", bcd0);
    end
  endtask

  task automatic test_stop_resume();
    pulse_clear();
    pulse_start();
    tk(42);
    stop = 1'b1; tick = 1'b1; step(); stop = 1'b0; tick = 1'b0;
    checks++;
    if ({bcd0, done0, run0} !== {16'h0042, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stop_tick got bcd=%h done=%b run=%b expected 0042 1 0",
               bcd0, done0, run0);
    end
    step();
    checks++;
    if (done0 !== 1'b0 || bcd0 !== 16'h0042) begin
      errors++;
      $display("FAIL done_width got done=%b bcd=%h expected 0 0042", done0, bcd0);
    end
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    tk(2);
    checks++;
    if (run0 !== 1'b0 || bcd0 !== 16'h0042) begin
      errors++;
      $display("FAIL hold_stopstart got run=%b bcd=%h expected 0 0042", run0, bcd0);
    end
    pulse_start();
    tk(1);
    checks++;
    if (bcd0 !== 16'h0043 || run0 !== 1'b1) begin
      errors++;
      $display("FAIL resume got bcd=%h run=%b expected 0043 1", bcd0, run0);
    end
  endtask

  task automatic test_overflow();
    pulse_clear();
    pulse_start();
    tk(9999);
    checks++;
    if (bcd0 !== 16'h9999 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL pre_ovf got bcd=%h ovf=%b expected 9999 0", bcd0, ovf0);
    end
    tk(1);
`ifdef TICK_BCD_TIMER_WRAP_EN
    checks++;
    if ({bcd0, ovf0, run0} !== {16'h0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap got bcd=%h ovf=%b run=%b expected 0000 1 1",
               bcd0, ovf0, run0);
    end
    tk(3);
    checks++;
    if (bcd0 !== 16'h0003 || ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky got bcd=%h ovf=%b expected 0003 1", bcd0, ovf0);
    end
`else
    checks++;
    if ({bcd0, ovf0, run0, done0} !== {16'h9999, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sat got bcd=%h ovf=%b run=%b done=%b expected 9999 1 0 0",
               bcd0, ovf0, run0, done0);
    end
    pulse_start();
    tk(3);
    checks++;
    if ({bcd0, ovf0, run0} !== {16'h9999, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sat_start got bcd=%h ovf=%b run=%b expected 9999 1 0",
               bcd0, ovf0, run0);
    end
`endif
    checks++;
    if (bcd1 !== to_bcd(m_cnt[1]) || run1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ps3 got bcd=%h run=%b expected %h 1",
               bcd1, run1, to_bcd(m_cnt[1]));
    end
  endtask

  task automatic test_prescale_clear();
    pulse_clear();
    pulse_start();
    tk(7);
    checks++;
    if (bcd1 !== 16'h0002) begin
      errors++; $display("FAIL prescale got %h expected 0002", bcd1);
    end
    clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
    checks++;
    if ({bcd0, bcd1, run0, run1, ovf0, ovf1} !== {32'h0, 4'b0}) begin
      errors++;
      $display("FAIL clear_start got %h %h run=%b%b ovf=%b%b expected 0 0 00 00",
               bcd0, bcd1, run0, run1, ovf0, ovf1);
    end
    tk(4);
    checks++;
    if (bcd0 !== 16'h0000 || bcd1 !== 16'h0000) begin
      errors++;
      $display("FAIL idle_ticks got %h %h expected 0000 0000", bcd0, bcd1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 59) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 7) == 0);
      tick  = ($urandom_range(0, 1) == 1);
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obcd[k] !== to_bcd(m_cnt[k])) begin
          errors++;
          $display("FAIL rnd_bcd%0d cyc %0d got %h expected %h",
                   k, n, obcd[k], to_bcd(m_cnt[k]));
        end
        checks++;
        if ({orun[k], odone[k], oovf[k]} !==
            {m_st[k] == M_RUN, m_done[k], m_ovf[k]}) begin
          errors++;
          $display("FAIL rnd_flags%0d cyc %0d got %b expected %b", k, n,
                   {orun[k], odone[k], oovf[k]},
                   {m_st[k] == M_RUN, m_done[k], m_ovf[k]});
        end
      end
    end
    reset = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0; tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_stop_resume();
    test_overflow();
    test_prescale_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
